// File: rtl/count_sequencer.sv
// Run controller for the 8-bit display counter: clears it, then paces one-cycle
// enable pulses from a selectable clock divider until stop, pause or the limit.
module count_sequencer #(
  parameter int CW    = 8,
  parameter int DW    = 26,
  parameter int RATE0 = 1,
  parameter int RATE1 = 12500000,
  parameter int RATE2 = 25000000,
  parameter int RATE3 = 50000000
) (
  input  logic          clk,
  input  logic          clear_b,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic [1:0]    rate_sel,
  input  logic [CW-1:0] limit,
  input  logic [CW-1:0] count,
  output logic          cnt_en,
  output logic          cnt_clear_b,
  output logic          tick,
  output logic [2:0]    state,
  output logic          done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A rate of 0 or 1 both mean "pulse every cycle", i.e. a reload of zero.
  function automatic logic [DW-1:0] reload_of(input int rate);
    if (rate > 1) begin
      reload_of = DW'(rate - 1);
    end else begin
      reload_of = {DW{1'b0}};
    end
  endfunction

  localparam logic [DW-1:0] RELOAD0 = reload_of(RATE0);
  localparam logic [DW-1:0] RELOAD1 = reload_of(RATE1);
  localparam logic [DW-1:0] RELOAD2 = reload_of(RATE2);
  localparam logic [DW-1:0] RELOAD3 = reload_of(RATE3);
  localparam logic [DW-1:0] DIV_ONE = {{(DW-1){1'b0}}, 1'b1};

  state_t        state_r;
  state_t        state_s;
  logic          start_q_r;
  logic          start_rise_s;
  logic [DW-1:0] div_cnt_r;
  logic [DW-1:0] reload_r;
  logic [DW-1:0] rate_reload_s;
  logic          cnt_clear_b_r;
  logic          at_limit_s;
  logic          tick_s;

  assign start_rise_s = start & ~start_q_r;
  assign at_limit_s   = (count == limit);
  assign tick_s       = (state_r == ST_RUN) && (div_cnt_r == {DW{1'b0}});

  assign tick        = tick_s;
  assign cnt_en      = tick_s & ~at_limit_s;
  assign cnt_clear_b = cnt_clear_b_r;
  assign state       = state_r;
  assign done        = (state_r == ST_DONE);

  // Reload value for the currently selected rate.
  always_comb begin
    rate_reload_s = RELOAD3;
    case (rate_sel)
      2'd0:    rate_reload_s = RELOAD0;
      2'd1:    rate_reload_s = RELOAD1;
      2'd2:    rate_reload_s = RELOAD2;
      default: rate_reload_s = RELOAD3;
    endcase
  end

  // Next-state decode: stop, then start edge, then limit, then pause.
  always_comb begin
    state_s = state_r;
    if (stop) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_rise_s) begin
            state_s = ST_CLR;
          end else begin
            state_s = state_r;
          end
        end
        ST_CLR: state_s = ST_RUN;
        ST_RUN: begin
          if (at_limit_s) begin
            state_s = ST_DONE;
          end else if (pause) begin
            state_s = ST_PAUSE;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_s = ST_PAUSE;
          end else begin
            state_s = ST_RUN;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, start-edge history and the glitch-free counter clear.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_r       <= ST_IDLE;
      start_q_r     <= 1'b0;
      cnt_clear_b_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      start_q_r     <= start;
      cnt_clear_b_r <= (state_s != ST_CLR);
    end
  end

  // Rate divider: latched in CLR, counts only in RUN so pause keeps its phase.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      div_cnt_r <= {DW{1'b0}};
      reload_r  <= {DW{1'b0}};
    end else if (state_r == ST_CLR) begin
      div_cnt_r <= rate_reload_s;
      reload_r  <= rate_reload_s;
    end else if (state_r == ST_RUN) begin
      if (tick_s) begin
        div_cnt_r <= reload_r;
      end else begin
        div_cnt_r <= div_cnt_r - DIV_ONE;
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Randomised and directed bench for count_sequencer, with an emulated counter and
// a cycle-level reference model of the run/pause/limit behaviour.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       clear_b;
  logic       start;
  logic       stop;
  logic       pause;
  logic [1:0] rate_sel;
  logic [7:0] limit;
  logic [7:0] count;
  logic       cnt_en;
  logic       cnt_clear_b;
  logic       tick;
  logic [2:0] state;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0..4 as numbered in the state output.
  int         m_mode;
  int         m_wait;
  int         m_rate;
  logic       m_startq;
  logic       m_clrb;
  logic [7:0] m_count;
  logic       o_en;

  always #5 clk = ~clk;

  count_sequencer #(
    .CW(8), .DW(26), .RATE0(1), .RATE1(4), .RATE2(3), .RATE3(2)
  ) dut (
    .clk(clk), .clear_b(clear_b), .start(start), .stop(stop), .pause(pause),
    .rate_sel(rate_sel), .limit(limit), .count(count), .cnt_en(cnt_en),
    .cnt_clear_b(cnt_clear_b), .tick(tick), .state(state), .done(done)
  );

  // The display counter being controlled.
  always @(posedge clk) begin
    if (!cnt_clear_b) count <= 8'd0;
    else if (cnt_en)  count <= count + 8'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int rate_of(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 4;
      2'd2:    return 3;
      default: return 2;
    endcase
  endfunction

  // One clock cycle: apply inputs, compare outputs with the model, advance the model.
  task automatic step(input logic st, input logic sp, input logic pa,
                      input logic [1:0] rs, input logic [7:0] lim);
    logic e_tick, e_en, rise;
    int   nxt;
    @(negedge clk);
    start = st; stop = sp; pause = pa; rate_sel = rs; limit = lim;
    #1;
    e_tick = (m_mode == 2) && (m_wait == 0);
    e_en   = e_tick && (m_count != lim);
    check_val("state", 32'(state), m_mode);
    check_val("tick", 32'(tick), 32'(e_tick));
    check_val("cnt_en", 32'(cnt_en), 32'(e_en));
    check_val("cnt_clear_b", 32'(cnt_clear_b), 32'(m_clrb));
    check_val("done", 32'(done), 32'(m_mode == 4));
    check_val("count", 32'(count), 32'(m_count));
    o_en = cnt_en;
    rise = st && !m_startq;
    if (sp)                                       nxt = 0;
    else if ((m_mode == 0 || m_mode == 4) && rise) nxt = 1;
    else if (m_mode == 1)                         nxt = 2;
    else if (m_mode == 2 && m_count == lim)       nxt = 4;
    else if (m_mode == 2 && pa)                   nxt = 3;
    else if (m_mode == 3 && !pa)                  nxt = 2;
    else                                          nxt = m_mode;
    if (m_mode == 1) begin
      m_rate = rate_of(rs);
      m_wait = m_rate - 1;
    end else if (m_mode == 2) begin
      m_wait = e_tick ? m_rate - 1 : m_wait - 1;
    end
    if (!m_clrb)   m_count = 8'd0;
    else if (e_en) m_count = m_count + 8'd1;
    m_clrb   = (nxt != 1);
    m_startq = st;
    m_mode   = nxt;
  endtask

  task automatic do_reset;
    @(negedge clk);
    clear_b = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    #1;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_cnt_clear_b", 32'(cnt_clear_b), 32'd0);
    check_val("rst_cnt_en", 32'(cnt_en), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    clear_b = 1'b1;
    m_mode = 0; m_wait = 0; m_rate = 1; m_startq = 1'b0; m_clrb = 1'b0; m_count = 8'd0;
  endtask

  initial begin
    int         pulses;
    int         gap;
    logic       cur_st;
    logic       cur_pa;
    logic [1:0] cur_rs;
    logic [7:0] cur_lim;
    clear_b = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    rate_sel = 2'd0; limit = 8'd0;
    do_reset();

    // Run to limit 5 at one pulse per cycle.
    pulses = 0;
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd5);
    repeat (30) begin
      step(1'b0, 1'b0, 1'b0, 2'd0, 8'd5);
      pulses += int'(o_en);
    end
    check_val("r0_pulses", 32'(pulses), 32'd5);
    check_val("r0_count", 32'(count), 32'd5);
    check_val("r0_done", 32'(done), 32'd1);

    // Divide by 4, limit 3.
    pulses = 0;
    step(1'b1, 1'b0, 1'b0, 2'd1, 8'd3);
    repeat (25) begin
      step(1'b0, 1'b0, 1'b0, 2'd1, 8'd3);
      pulses += int'(o_en);
    end
    check_val("r1_pulses", 32'(pulses), 32'd3);
    check_val("r1_count", 32'(count), 32'd3);
    check_val("r1_done", 32'(done), 32'd1);

    // Pause for 10 cycles after the 2nd RUN cycle; phase must be preserved.
    step(1'b1, 1'b0, 1'b0, 2'd1, 8'd200);
    step(1'b0, 1'b0, 1'b0, 2'd1, 8'd200);
    step(1'b0, 1'b0, 1'b0, 2'd1, 8'd200);
    repeat (10) step(1'b0, 1'b0, 1'b1, 2'd1, 8'd200);
    gap = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'd1, 8'd200);
      if (o_en && gap < 0) gap = i;
    end
    check_val("pause_gap", 32'(gap), 32'd2);
    step(1'b0, 1'b1, 1'b0, 2'd1, 8'd200);

    // Limit, pause and stop together: stop wins.
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd2);
    repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd2);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd2);
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'd2);
    check_val("prio_stop", 32'(state), 32'd0);
    // Same without stop: limit beats pause.
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd2);
    repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd2);
    step(1'b0, 1'b0, 1'b1, 2'd0, 8'd2);
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'd2);
    check_val("prio_limit", 32'(state), 32'd4);

    // Restart from DONE clears the counter.
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd2);
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'd2);
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'd2);
    check_val("restart_count", 32'(count), 32'd0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd2);

    // Limit zero: straight to DONE with no pulses.
    pulses = 0;
    step(1'b1, 1'b0, 1'b0, 2'd2, 8'd0);
    repeat (6) begin
      step(1'b0, 1'b0, 1'b0, 2'd2, 8'd0);
      pulses += int'(o_en);
    end
    check_val("lim0_pulses", 32'(pulses), 32'd0);
    check_val("lim0_done", 32'(done), 32'd1);

    // Start edge while running is ignored.
    step(1'b1, 1'b0, 1'b0, 2'd3, 8'd100);
    step(1'b0, 1'b0, 1'b0, 2'd3, 8'd100);
    step(1'b0, 1'b0, 1'b0, 2'd3, 8'd100);
    step(1'b1, 1'b0, 1'b0, 2'd3, 8'd100);
    step(1'b1, 1'b0, 1'b0, 2'd3, 8'd100);
    check_val("run_restart_ignored", 32'(state), 32'd2);
    step(1'b0, 1'b1, 1'b0, 2'd3, 8'd100);

    // Reset in the middle of a run with count at 37.
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd100);
    repeat (38) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd100);
    @(posedge clk);
    #1;
    check_val("pre_rst_count", 32'(count), 32'd37);
    check_val("pre_rst_state", 32'(state), 32'd2);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'd100);
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'd100);
    check_val("post_rst_clear_b", 32'(cnt_clear_b), 32'd1);

    // Random traffic against the model.
    cur_st = 1'b0; cur_pa = 1'b0; cur_rs = 2'd0; cur_lim = 8'd4;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0)   cur_st = ~cur_st;
      if ($urandom_range(0, 7) == 0)   cur_pa = ~cur_pa;
      if ($urandom_range(0, 3) == 0)   cur_rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0)  cur_lim = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 600) == 0) begin
        do_reset();
        cur_st = 1'b0;
      end
      step(cur_st, 1'($urandom_range(0, 60) == 0), cur_pa, cur_rs, cur_lim);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Run controller for the 8-bit T-flip-flop counter that drives the two-digit hex display.
- Holds the counter in clear, then issues one-cycle enable pulses at a selectable rate derived from the board clock.
- Supports pause and stop, and halts when the counter reaches a programmed limit.
- Sits between the user switches/keys and the counter's enable/clear inputs; the counter value returns as feedback for the limit compare.

Parameters:
- CW, 8: counter width (limit and count feedback).
- DW, 26: rate-divider width.
- RATE0, 1: clock cycles per enable pulse when rate_sel=0.
- RATE1, 12500000: cycles per pulse, rate_sel=1.
- RATE2, 25000000: cycles per pulse, rate_sel=2.
- RATE3, 50000000: cycles per pulse, rate_sel=3.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clear_b  in  1  asynchronous, active-low reset.
- start  in  1  level input; rising edge (registered edge detect) requests a run.
- stop  in  1  level; while high, forces IDLE.
- pause  in  1  level; while high, RUN suspends.
- rate_sel  in  2  selects RATE0..RATE3.
- limit  in  CW  terminal count.
- count  in  CW  counter value feedback.
- cnt_en  out  1  counter enable (T input of the counter's top stage).
- cnt_clear_b  out  1  registered active-low clear to the counter.
- tick  out  1  divider terminal pulse.
- state  out  3  IDLE=0, CLR=1, RUN=2, PAUSE=3, DONE=4.
- done  out  1  high when state is DONE.

Behaviour:
- Reset (async, clear_b=0):
  - state=IDLE; div_cnt=0; start edge register=0.
  - cnt_en=0; tick=0; done=0.
  - cnt_clear_b=0, so the counter is held clear during reset. It goes to 1 on the first clock edge after release.
- Reset mid-operation aborts immediately; no pulse is completed.
- Start edge: start_q registers start; start_rise = start & ~start_q.
- Next-state priority, highest first: stop, start_rise, limit compare, pause.
- stop=1: next state is IDLE from any state. Counter is not cleared and holds its value.
- IDLE or DONE, start_rise=1: go to CLR.
- CLR (exactly one cycle):
  - cnt_clear_b=0 during this cycle, registered so it is glitch-free.
  - rate_sel is sampled; div_cnt loads max(RATEsel,1)-1.
  - Next state is RUN unconditionally, unless stop=1.
- rate_sel changes outside CLR have no effect until the next start.
- RUN:
  - tick = (div_cnt==0). When tick=1, div_cnt reloads the latched rate minus 1; otherwise it decrements.
  - cnt_en = tick & (count != limit), combinational from registered state and the count input.
  - If count==limit: cnt_en=0 and next state is DONE; limit beats pause in the same cycle.
  - Else if pause=1: next state is PAUSE. A tick occurring in that same cycle still produces cnt_en.
  - start_rise in RUN or PAUSE is ignored.
- PAUSE: div_cnt frozen; tick=0; cnt_en=0. When pause=0, return to RUN with the divider phase preserved.
- DONE: cnt_en=0; done=1; div_cnt held. The counter keeps showing limit.
- Timing from the first RUN cycle R, latched rate N:
  - First cnt_en occurs in cycle R+N-1, then every N cycles.
  - The counter updates at the edge ending each cnt_en cycle.
- limit=0: after CLR, count==0, so the first RUN cycle goes to DONE with no pulses.
- Ticks in IDLE, CLR, PAUSE and DONE are always 0.
- Counter wrap (255 to 0) occurs only if limit is unreachable; it cannot be, because every value 0..255 is reachable.
- cnt_en is never high in the cycle the state register leaves RUN for DONE.

Test Plan:
- Reset: clear_b low mid-RUN with count=37 → state=0, cnt_clear_b=0, cnt_en=0 immediately. After release, one edge later cnt_clear_b=1 and state stays IDLE.
- Run to limit, RATE0=1, limit=5, start rising:
  - one CLR cycle with cnt_clear_b=0;
  - then 5 consecutive cnt_en cycles, count 0→5;
  - the next cycle enters DONE with done=1, and count stays 5 for 20 more cycles.
- Divider, RATE1=4 (bench override), limit=3: cnt_en asserts in RUN cycles 3, 7 and 11 only. DONE follows count reaching 3.
- Pause phase, RATE1=4: pause high for 10 cycles after the 2nd RUN cycle. The next cnt_en arrives exactly 2 cycles after pause drops, and tick=0 throughout PAUSE.
- Priority, with count==limit, pause=1 and stop=1 in the same cycle: next state is IDLE. Repeat with stop=0: next state is DONE.
- Restart and limit zero:
  - start rising in DONE → CLR, then count=0, then a new run;
  - limit=0 → DONE on the first RUN cycle with zero cnt_en pulses;
  - start rising while in RUN → no state change.
